arythm_mac_pipe: RTL and testbench
==================================

// Module: arythm_mac_pipe
// PURPOSE
//  Parametrised, pipelined signed fixed-point multiply-add / multiply-accumulate.
//  Mode 0 computes out = A*B + C per sample; mode 1 keeps a running sum acc += A*B.
//  Fixed 3-cycle latency, with clock-enable stall and valid tracking.
//  Output is saturated to OUT_W, with an overflow flag.
//  Sits in the arithmetic datapath as the next generation of the 12-bit A*B+C unit.
// PARAMETERS
//  W     = 12 : width of A, B and C; two's complement, Q(W-FRAC).FRAC
//  FRAC  = 10 : fractional bits of A, B and C; out has 2*FRAC fractional bits
//  OUT_W = 25 : output width; must be >= 2*W+1
//  GUARD = 8  : extra accumulator bits above OUT_W (mode 1 only)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  ce         in   1       clock enable; 0 freezes the whole pipeline
//  in_valid   in   1       A, B, C, mode and acc_clr are valid this cycle
//  mode       in   1       0 = A*B+C, 1 = accumulate
//  acc_clr    in   1       mode 1 only: this sample seeds acc = A*B + C_al
//  A          in   W       signed operand
//  B          in   W       signed operand
//  C          in   W       signed addend / accumulator seed
//  out        out  OUT_W   signed result, 2*FRAC fractional bits
//  out_valid  out  1       out holds a new result
//  sat        out  1       out was clipped this result
// BEHAVIOUR
//  Reset (async, immediate): all pipe registers, acc, out, out_valid and sat go to 0.
//   - In-flight samples are discarded; no valid appears after rst deasserts.
//  ce=0: no register changes, including valid bits and acc.
//   - in_valid is ignored while ce=0.
//   - out, out_valid and sat hold their values.
//  Pipeline, each stage advancing only when ce=1:
//   - S1 registers A, B, C, mode, acc_clr and in_valid.
//   - S2: P = A*B, signed, 2W bits. C_al = C sign-extended and shifted left by FRAC.
//   - S3 computes, registers out, and sets out_valid = S2 valid.
//  Latency: a sample accepted at edge n gives its result at edge n+3 when ce=1 throughout.
//   - Each ce=0 cycle adds one cycle of latency.
//  Throughput: one sample per ce cycle.
//  Bubbles (valid=0):
//   - never change acc;
//   - give out_valid=0 while out keeps its last value.
//  Mode 0: out = P + C_al, sign-extended to OUT_W.
//   - Cannot overflow when OUT_W >= 2W+1, so sat=0.
//   - acc is untouched.
//  Mode 1, with OUT_W+GUARD-bit accumulator:
//   - acc_clr=1: acc = P + C_al.
//   - acc_clr=0: acc = acc + P; C is ignored.
//   - out = acc clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 when clipped.
//   - acc itself is not clipped.
//   - acc wraps at OUT_W+GUARD bits; the bench must not exceed 2^GUARD full-scale products.
//  Mixed modes: a mode-0 sample between mode-1 samples leaves acc intact.
//  Mid-stream changes: mode and acc_clr travel with their sample; no flush is needed.
//  sat is valid only when out_valid=1; it is 0 otherwise.
// TESTING
//  1. Mode 0: A=0x14B, B=0xCDA, C=0x243 (0.3232, -0.7871, 0.5654)
//     -> out = 326110 (0x004F9DE) at edge n+3; out_valid pulses 1 cycle; sat=0.
//  2. Mode 0: A=B=0x800, C=0x7FF -> out = 4194304 + 2096128 = 6290432; sat=0.
//  3. Mode 1: acc_clr=1 with C=0, then A=B=0x7FF for 5 samples in a row
//     -> out = 4190209, 8380418, 12570627, 16760836, then 16777215 with sat=1.
//  4. Mode 1, negative: A=0x800, B=0x7FF x5 -> 5th out = -16777216 (0x1000000), sat=1.
//  5. Stall: ce=0 for 2 cycles after test-1 input is accepted
//     -> result at edge n+5; out and out_valid frozen while ce=0.
//  6. rst pulsed with 2 samples in flight and acc nonzero
//     -> out=0, out_valid=0, sat=0 at once and no later valid.
//     -> Next mode-1 sample with acc_clr=0 gives out = P alone.

Source files
------------

// File: rtl/arythm_mac_pipe.sv
// Three-stage signed fixed-point multiply-add / multiply-accumulate with
// clock-enable stall, valid tracking and saturating output.
module arythm_mac_pipe #(
    parameter int unsigned W     = 12,
    parameter int unsigned FRAC  = 10,
    parameter int unsigned OUT_W = 25,
    parameter int unsigned GUARD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    mode,
    input  logic                    acc_clr,
    input  logic        [W-1:0]     A,
    input  logic        [W-1:0]     B,
    input  logic        [W-1:0]     C,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    output logic                    sat
);

    localparam int unsigned PW    = 2 * W;
    localparam int unsigned CW    = W + FRAC;
    localparam int unsigned ACC_W = OUT_W + GUARD;
    localparam int unsigned HI_W  = ACC_W - OUT_W + 1;

    // Stage 1: registered inputs
    logic         s1_valid_q, s1_mode_q, s1_clr_q;
    logic [W-1:0] s1_a_q, s1_b_q, s1_c_q;

    // Stage 2: product and aligned addend
    logic          s2_valid_q, s2_mode_q, s2_clr_q;
    logic [PW-1:0] s2_p_q, s2_p_d;
    logic [CW-1:0] s2_cal_q, s2_cal_d;

    // Stage 3: accumulator and output registers
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             sat_q, sat_d;

    logic [ACC_W-1:0] p_ext, cal_ext, sum_pc, sum_acc;
    logic [HI_W-1:0]  acc_hi;

    always_comb begin
        s2_p_d   = $signed({{W{s1_a_q[W-1]}}, s1_a_q}) * $signed({{W{s1_b_q[W-1]}}, s1_b_q});
        s2_cal_d = {s1_c_q, {FRAC{1'b0}}};
    end

    always_comb begin
        p_ext   = {{(ACC_W - PW){s2_p_q[PW-1]}}, s2_p_q};
        cal_ext = {{(ACC_W - CW){s2_cal_q[CW-1]}}, s2_cal_q};
        sum_pc  = p_ext + cal_ext;
        sum_acc = acc_q + p_ext;
    end

    // Result stage: bubbles hold out and acc, sat only accompanies a valid result
    always_comb begin
        acc_d       = acc_q;
        out_d       = out_q;
        sat_d       = 1'b0;
        out_valid_d = s2_valid_q;
        acc_hi      = '0;
        if (s2_valid_q) begin
            if (!s2_mode_q) begin
                out_d = sum_pc[OUT_W-1:0];
            end else begin
                acc_d  = s2_clr_q ? sum_pc : sum_acc;
                acc_hi = acc_d[ACC_W-1:OUT_W-1];
                if ((&acc_hi) || !(|acc_hi)) begin
                    out_d = acc_d[OUT_W-1:0];
                end else begin
                    sat_d = 1'b1;
                    out_d = acc_d[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_clr_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_clr_q    <= 1'b0;
            s2_p_q      <= '0;
            s2_cal_q    <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else if (ce) begin
            s1_valid_q  <= in_valid;
            s1_mode_q   <= mode;
            s1_clr_q    <= acc_clr;
            s1_a_q      <= A;
            s1_b_q      <= B;
            s1_c_q      <= C;
            s2_valid_q  <= s1_valid_q;
            s2_mode_q   <= s1_mode_q;
            s2_clr_q    <= s1_clr_q;
            s2_p_q      <= s2_p_d;
            s2_cal_q    <= s2_cal_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out       = $signed(out_q);
    assign out_valid = out_valid_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_arythm_mac_pipe.sv
// Directed self-checking bench for arythm_mac_pipe (default parameters).
module tb_arythm_mac_pipe;

    logic               clk = 1'b0;
    logic               rst, ce, in_valid, mode, acc_clr;
    logic        [11:0] A, B, C;
    logic signed [24:0] out;
    logic               out_valid, sat;

    int checks = 0;
    int errors = 0;

    arythm_mac_pipe dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
        .acc_clr(acc_clr), .A(A), .B(B), .C(C),
        .out(out), .out_valid(out_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic clr,
                         input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        in_valid = v; mode = m; acc_clr = clr; A = a; B = b; C = c;
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        #3;
        checks++; if (out !== 25'sd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
        step; step;
        rst = 1'b0;
        step;
    endtask

    task automatic test_mode0;
        drive(1'b1, 1'b0, 1'b0, 12'h14B, 12'hCDA, 12'h243);
        step;
        drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m0_early_valid: got %b expected 0", out_valid); end
        step;
        checks++; if (out !== 25'sd326110) begin errors++; $display("FAIL m0_out: got %0d expected 326110", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m0_valid: got %b expected 1", out_valid); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL m0_sat: got %b expected 0", sat); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m0_pulse: got %b expected 0", out_valid); end
        checks++; if (out !== 25'sd326110) begin errors++; $display("FAIL m0_hold: got %0d expected 326110", out); end
    endtask

    task automatic test_mode0_corner;
        drive(1'b1, 1'b0, 1'b0, 12'h800, 12'h800, 12'h7FF);
        step;
        drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        step; step;
        checks++; if (out !== 25'sd6290432) begin errors++; $display("FAIL m0c_out: got %0d expected 6290432", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m0c_valid: got %b expected 1", out_valid); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL m0c_sat: got %b expected 0", sat); end
        step;
    endtask

    task automatic test_accum(input string name, input logic [11:0] a, input logic [11:0] b,
                              input longint exp_v [5]);
        logic signed [24:0] e;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1'b1, 1'b1, (i == 0), a, b, 12'h000);
            else       drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
            step;
            if (i >= 2) begin
                e = 25'(exp_v[i-2]);
                checks++; if (out !== e) begin errors++; $display("FAIL %s_out%0d: got %0d expected %0d", name, i-2, out, e); end
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid%0d: got %b expected 1", name, i-2, out_valid); end
                checks++; if (sat !== (i == 6)) begin errors++; $display("FAIL %s_sat%0d: got %b expected %b", name, i-2, sat, (i == 6)); end
            end
        end
        step;
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL %s_sat_bubble: got %b expected 0", name, sat); end
    endtask

    task automatic test_stall;
        drive(1'b1, 1'b0, 1'b0, 12'h14B, 12'hCDA, 12'h243);
        step;
        drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d: got %b expected 0", i, out_valid); end
        end
        ce = 1'b1;
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_early: got %b expected 0", out_valid); end
        step;
        checks++; if (out !== 25'sd326110) begin errors++; $display("FAIL stall_out: got %0d expected 326110", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_result_valid: got %b expected 1", out_valid); end
        // in_valid offered while stalled must be ignored
        ce = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 12'h7FF, 12'h7FF, 12'h000);
        for (int i = 0; i < 2; i++) begin
            step;
            checks++; if (out_valid !== 1'b1 || out !== 25'sd326110) begin
                errors++; $display("FAIL stall_freeze%0d: got %0d/%b expected 326110/1", i, out, out_valid);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_ignored%0d: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] va [4] = '{12'h400, 12'h14B, 12'h400, 12'h200};
        logic [11:0] vb [4] = '{12'h400, 12'hCDA, 12'h400, 12'h200};
        logic [11:0] vc [4] = '{12'h000, 12'h243, 12'h000, 12'h400};
        logic        vm [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        vk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic signed [24:0] ev [4] = '{25'sd1048576, 25'sd326110, 25'sd2097152, 25'sd1310720};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, vm[i], vk[i], va[i], vb[i], vc[i]);
            else       drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
            step;
            if (i >= 2) begin
                checks++; if (out !== ev[i-2] || out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_out%0d: got %0d/%b expected %0d/1", i-2, out, out_valid, ev[i-2]);
                end
            end
        end
        step;
    endtask

    task automatic test_reset_inflight;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, (i == 0), 12'h7FF, 12'h7FF, 12'h000);
            step;
        end
        drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        checks++; if (out !== 25'sd4190209) begin errors++; $display("FAIL rsti_pre: got %0d expected 4190209", out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out !== 25'sd0 || out_valid !== 1'b0 || sat !== 1'b0) begin
            errors++; $display("FAIL rsti_async: got %0d/%b/%b expected 0/0/0", out, out_valid, sat);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rsti_ghost%0d: got %b expected 0", i, out_valid); end
        end
        drive(1'b1, 1'b1, 1'b0, 12'h14B, 12'hCDA, 12'h000);
        step;
        drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
        step; step;
        checks++; if (out !== -25'sd266786 || out_valid !== 1'b1 || sat !== 1'b0) begin
            errors++; $display("FAIL rsti_acc: got %0d/%b/%b expected -266786/1/0", out, out_valid, sat);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode0_corner;
        test_accum("acc_pos", 12'h7FF, 12'h7FF,
                   '{64'sd4190209, 64'sd8380418, 64'sd12570627, 64'sd16760836, 64'sd16777215});
        test_accum("acc_neg", 12'h800, 12'h7FF,
                   '{-64'sd4192256, -64'sd8384512, -64'sd12576768, -64'sd16769024, -64'sd16777216});
        test_stall;
        test_back_to_back;
        test_reset_inflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
